// File: rtl/ltc_decoder.sv
// rtl/ltc_decoder.sv - SMPTE 12M LTC biphase-mark decoder and frame parser; `define LTC_DEC_USER_BITS_EN to load user_bits
module ltc_decoder #(
  parameter int CLK_FREQ = 25000000,
  parameter int LTC_FPS  = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ltc_in,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        locked,
  output logic [4:0]  time_hour,
  output logic [5:0]  time_minute,
  output logic [5:0]  time_second,
  output logic [4:0]  time_frame,
  output logic        drop_frame,
  output logic        color_frame,
  output logic [31:0] user_bits
);

  localparam int BIT_CYC = CLK_FREQ / (LTC_FPS * 80);
  localparam int CNT_W   = $clog2(2 * BIT_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] T_GLITCH = CNT_W'(BIT_CYC / 4);
  localparam logic [CNT_W-1:0] T_SHORT  = CNT_W'(3 * BIT_CYC / 4);
  localparam logic [CNT_W-1:0] T_LONG   = CNT_W'(3 * BIT_CYC / 2);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC1  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             sync1, sync2, sync3;
  logic             line_edge;
  logic [CNT_W-1:0] cnt;
  logic             half_pend;
  logic             is_glitch, is_short, is_long, timeout;
  logic             line_err, emit;
  logic             bit_v, bit_d;
  logic [79:0]      sr;
  logic             shifted;
  logic [6:0]       bitcnt;
  logic             sync_hit, at_frame_len;
  logic [6:0]       frame_bin, second_bin, minute_bin, hour_bin;
  logic             fields_ok;

  // Two-stage synchroniser plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ltc_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign line_edge = sync2 ^ sync3;

  // Classify the interval ending at this edge; timeout only counts when no edge arrives
  always_comb begin
    is_glitch = (cnt < T_GLITCH);
    is_short  = !is_glitch && (cnt < T_SHORT);
    is_long   = !is_glitch && !is_short && (cnt <= T_LONG);
    timeout   = (cnt > T_LONG);
    if (line_edge) begin
      line_err = is_glitch || !(is_short || is_long) || (is_long && half_pend);
      emit     = (is_long && !half_pend) || (is_short && half_pend);
    end else begin
      line_err = timeout;
      emit     = 1'b0;
    end
  end

  // Interval counter, half-cell tracking and recovered-bit register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      half_pend <= 1'b0;
      bit_v     <= 1'b0;
      bit_d     <= 1'b0;
    end else begin
      bit_v <= emit;
      bit_d <= is_short;
      if (line_edge) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (line_err) begin
        half_pend <= 1'b0;
      end else if (line_edge && is_short) begin
        half_pend <= !half_pend;
      end
    end
  end

  // Recovered bits enter at the MSB so sr[i] lines up with frame bit i
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      shifted <= 1'b0;
    end else begin
      shifted <= bit_v;
      if (bit_v) begin
        sr <= {bit_d, sr[79:1]};
      end
    end
  end

  assign sync_hit     = shifted && (sr[79:64] == 16'hBFFC);
  assign at_frame_len = (bitcnt == 7'd79);

  // Bits since the last sync word; saturates so a long search never aliases to 79
  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt <= '0;
    end else if (shifted) begin
      if (sync_hit) begin
        bitcnt <= '0;
      end else if (bitcnt != 7'd127) begin
        bitcnt <= bitcnt + 7'd1;
      end
    end
  end

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Line errors always drop to search; otherwise the lock evolves once per recovered bit
  always_comb begin
    state_d = state_q;
    if (line_err) begin
      state_d = ST_SEARCH;
    end else if (shifted) begin
      case (state_q)
        ST_SEARCH: if (sync_hit) state_d = ST_SYNC1;
        ST_SYNC1:  if (sync_hit && at_frame_len) state_d = ST_LOCKED;
        ST_LOCKED: if (sync_hit != at_frame_len) state_d = ST_SEARCH;
        default:   state_d = ST_SEARCH;
      endcase
    end
  end

  // Lock indication is purely a function of state
  always_comb begin
    locked = (state_q == ST_LOCKED);
  end

  // BCD tens/units to binary and range check of the frame held in sr
  always_comb begin
    frame_bin  = 7'(sr[9:8])   * 7'd10 + 7'(sr[3:0]);
    second_bin = 7'(sr[26:24]) * 7'd10 + 7'(sr[19:16]);
    minute_bin = 7'(sr[42:40]) * 7'd10 + 7'(sr[35:32]);
    hour_bin   = 7'(sr[57:56]) * 7'd10 + 7'(sr[51:48]);
    fields_ok  = (sr[3:0] <= 4'd9) && (sr[19:16] <= 4'd9) &&
                 (sr[35:32] <= 4'd9) && (sr[51:48] <= 4'd9) &&
                 (hour_bin <= 7'd23) && (minute_bin <= 7'd59) &&
                 (second_bin <= 7'd59) && (frame_bin <= 7'(LTC_FPS - 1));
  end

  // Load time fields and raise exactly one strobe on each sync word
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      time_hour   <= '0;
      time_minute <= '0;
      time_second <= '0;
      time_frame  <= '0;
      drop_frame  <= 1'b0;
      color_frame <= 1'b0;
    end else begin
      frame_valid <= sync_hit && fields_ok;
      frame_err   <= sync_hit && !fields_ok;
      if (sync_hit && fields_ok) begin
        time_hour   <= hour_bin[4:0];
        time_minute <= minute_bin[5:0];
        time_second <= second_bin[5:0];
        time_frame  <= frame_bin[4:0];
        drop_frame  <= sr[10];
        color_frame <= sr[11];
      end
    end
  end

`ifdef LTC_DEC_USER_BITS_EN
  // User fields 1..8 load together with the time fields
  always_ff @(posedge clk) begin
    if (reset) begin
      user_bits <= '0;
    end else if (sync_hit && fields_ok) begin
      user_bits <= {sr[63:60], sr[55:52], sr[47:44], sr[39:36],
                    sr[31:28], sr[23:20], sr[15:12], sr[7:4]};
    end
  end
`else
  assign user_bits = '0;
`endif

endmodule

// File: tb/tb_ltc_decoder.sv
// tb/tb_ltc_decoder.sv - scoreboard bench for ltc_decoder driven by a biphase-mark line model
`timescale 1ns/1ps
module tb_ltc_decoder;

  localparam int FPS      = 25;
  localparam int BIT_CYC  = 16;
  localparam int HALF     = BIT_CYC / 2;
  localparam int CLK_FREQ = FPS * 80 * BIT_CYC;

  logic        clk = 1'b0;
  logic        reset;
  logic        ltc_in;
  logic        frame_valid, frame_err, locked;
  logic [4:0]  time_hour, time_frame;
  logic [5:0]  time_minute, time_second;
  logic        drop_frame, color_frame;
  logic [31:0] user_bits;

  ltc_decoder #(.CLK_FREQ(CLK_FREQ), .LTC_FPS(FPS)) dut (
    .clk(clk), .reset(reset), .ltc_in(ltc_in),
    .frame_valid(frame_valid), .frame_err(frame_err), .locked(locked),
    .time_hour(time_hour), .time_minute(time_minute), .time_second(time_second),
    .time_frame(time_frame), .drop_frame(drop_frame), .color_frame(color_frame),
    .user_bits(user_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [55:0] out;
    bit          lk;
  } exp_t;

  exp_t        expq[$];
  bit          hist[$];
  int          bit_idx, last_sync, mstate;
  logic [55:0] last_out;
  int          checks = 0;
  int          errors = 0;

  // Decoded-stream reference: the last 80 recovered bits, scanned for a sync word after every bit
  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 80; i++) hist.push_back(1'b0);
    bit_idx = 0; last_sync = -1; mstate = 0; last_out = '0;
  endtask

  task automatic model_error();
    mstate = 0;
  endtask

  task automatic model_bit(input bit b);
    logic [79:0] w;
    logic [31:0] ub;
    int gap, fr, se, mi, hr;
    bit is_sync, on_time, ok;
    exp_t e;
    hist.push_back(b);
    void'(hist.pop_front());
    for (int i = 0; i < 80; i++) w[i] = hist[i];
    gap = bit_idx - last_sync;
    on_time = (gap == 80);
    is_sync = (w[79:64] == 16'hBFFC);
    if (is_sync) last_sync = bit_idx;
    bit_idx++;
    // 0 = searching, 1 = one sync seen, 2 = syncs arriving one frame apart
    if (is_sync) begin
      if (mstate == 0) mstate = 1;
      else if (on_time) mstate = 2;
      else if (mstate == 2) mstate = 0;
    end else if (mstate == 2 && on_time) begin
      mstate = 0;
    end
    if (is_sync) begin
      fr = 10 * w[9:8] + w[3:0];
      se = 10 * w[26:24] + w[19:16];
      mi = 10 * w[42:40] + w[35:32];
      hr = 10 * w[57:56] + w[51:48];
      ok = (w[3:0] <= 9) && (w[19:16] <= 9) && (w[35:32] <= 9) && (w[51:48] <= 9) &&
           (hr <= 23) && (mi <= 59) && (se <= 59) && (fr <= FPS - 1);
`ifdef LTC_DEC_USER_BITS_EN
      ub = {w[63:60], w[55:52], w[47:44], w[39:36], w[31:28], w[23:20], w[15:12], w[7:4]};
`else
      ub = '0;
`endif
      if (ok) last_out = {hr[4:0], mi[5:0], se[5:0], fr[4:0], w[10], w[11], ub};
      e.is_err = !ok;
      e.out    = last_out;
      e.lk     = (mstate == 2);
      expq.push_back(e);
    end
  endtask

  function automatic logic [79:0] make_frame(input int h, input int m, input int s, input int f,
                                             input logic [31:0] ub);
    logic [79:0] fb;
    fb = '0;
    fb[3:0]   = 4'(f % 10);  fb[7:4]   = ub[3:0];   fb[9:8]   = 2'(f / 10);
    fb[10]    = 1'($urandom_range(0, 1)); fb[11] = 1'($urandom_range(0, 1));
    fb[15:12] = ub[7:4];     fb[19:16] = 4'(s % 10); fb[23:20] = ub[11:8];
    fb[26:24] = 3'(s / 10);  fb[27]    = 1'($urandom_range(0, 1)); fb[31:28] = ub[15:12];
    fb[35:32] = 4'(m % 10);  fb[39:36] = ub[19:16]; fb[42:40] = 3'(m / 10);
    fb[43]    = 1'($urandom_range(0, 1)); fb[47:44] = ub[23:20];
    fb[51:48] = 4'(h % 10);  fb[55:52] = ub[27:24]; fb[57:56] = 2'(h / 10);
    fb[59:58] = 2'($urandom_range(0, 3)); fb[63:60] = ub[31:28];
    fb[79:64] = 16'hBFFC;
    return fb;
  endfunction

  function automatic logic [79:0] frame_at(input int n);
    return make_frame((n / (FPS * 3600)) % 24, (n / (FPS * 60)) % 60, (n / FPS) % 60, n % FPS, $urandom());
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Biphase mark: transition at every cell start, extra mid-cell transition for a one
  task automatic tx_bit(input bit b);
    model_bit(b);
    ltc_in = ~ltc_in;
    if (b) begin
      tick(HALF); ltc_in = ~ltc_in; tick(HALF);
    end else begin
      tick(BIT_CYC);
    end
  endtask

  task automatic tx_frame(input logic [79:0] fb, input int nbits);
    for (int i = 0; i < nbits; i++) tx_bit(fb[i]);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({frame_valid, frame_err, locked, time_hour, time_minute, time_second, time_frame,
         drop_frame, color_frame, user_bits} !== '0) begin
      errors++;
      $display("FAIL %s outputs h=%0d m=%0d s=%0d f=%0d lk=%0b ub=%h required all zero",
               name, time_hour, time_minute, time_second, time_frame, locked, user_bits);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0b required %0b", name, act, req);
    end
  endtask

  // Monitor: every strobe pops one expected response from the scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [55:0] act;
    if (!reset && (frame_valid || frame_err)) begin
      act = {time_hour, time_minute, time_second, time_frame, drop_frame, color_frame, user_bits};
      checks++;
      if (frame_valid && frame_err) begin
        errors++;
        $display("FAIL strobe_overlap valid=1 err=1 required one strobe");
      end else if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe valid=%0b err=%0b required none", frame_valid, frame_err);
      end else begin
        e = expq.pop_front();
        if (frame_err !== e.is_err) begin
          errors++;
          $display("FAIL strobe_kind err=%0b required %0b", frame_err, e.is_err);
        end
        checks++;
        if (act !== e.out) begin
          errors++;
          $display("FAIL fields got %h required %h", act, e.out);
        end
        checks++;
        if (locked !== e.lk) begin
          errors++;
          $display("FAIL locked_at_strobe got %0b required %0b", locked, e.lk);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] fb;
    int drop_at;
    ltc_in = 1'b0;
    reset  = 1'b1;
    model_reset();
    tick(4);
    check_zero("reset_values");
    reset = 1'b0;
    tick(2 * BIT_CYC);

    // Continuous stream from 00:00:00:00 through the first second rollover
    for (int n = 0; n < 27; n++) tx_frame(frame_at(n), 80);
    check_bit("locked_after_stream", locked, 1'b1);

    // Maximum legal time, then an invalid minute-units field, then a normal frame
    tx_frame(make_frame(23, 59, 59, FPS - 1, 32'h12345678), 80);
    fb = make_frame(12, 34, 56, 7, $urandom());
    fb[35:32] = 4'hA;
    tx_frame(fb, 80);
    tx_frame(frame_at(100), 80);

    // Static line: closing transition, then no edges
    ltc_in = ~ltc_in;
    drop_at = -1;
    for (int i = 1; i <= 3 * BIT_CYC / 2 + 5; i++) begin
      tick(1);
      if (drop_at < 0 && !locked) drop_at = i;
    end
    checks++;
    if (drop_at < 0) begin
      errors++;
      $display("FAIL timeout_unlock locked=%0b required 0", locked);
    end else if (drop_at <= 3 * BIT_CYC / 2) begin
      errors++;
      $display("FAIL timeout_early dropped after %0d cycles required more than %0d", drop_at, 3 * BIT_CYC / 2);
    end
    model_error();
    tick(2 * BIT_CYC);
    tx_frame(frame_at(200), 80);
    tx_frame(frame_at(201), 80);
    tx_frame(frame_at(202), 80);
    check_bit("relock_after_timeout", locked, 1'b1);

    // Short glitch pulse in the middle of a frame, then the line stops
    tx_frame(frame_at(300), 40);
    ltc_in = ~ltc_in; tick(3);
    ltc_in = ~ltc_in; tick(3);
    ltc_in = ~ltc_in;
    model_error();
    tick(6);
    check_bit("glitch_unlock", locked, 1'b0);
    tick(2 * BIT_CYC);
    for (int n = 400; n < 403; n++) tx_frame(frame_at(n), 80);
    check_bit("relock_after_glitch", locked, 1'b1);

    // Reset in the middle of bit 40
    tx_frame(frame_at(500), 40);
    ltc_in = ~ltc_in;
    tick(HALF);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending_before_reset got %0d required 0", expq.size());
      expq.delete();
    end
    reset = 1'b1;
    tick(1);
    check_zero("midframe_reset");
    reset = 1'b0;
    model_reset();
    tick(2 * BIT_CYC);
    for (int n = 600; n < 603; n++) tx_frame(frame_at(n), 80);
    ltc_in = ~ltc_in;
    tick(BIT_CYC);
    check_bit("locked_after_reset_resync", locked, 1'b1);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got %0d pending required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
